instr_fetch_unit: RTL and testbench

- Fetch stage wrapped around the program counter register.
- Computes the next-PC value that feeds the PC register's input every cycle.
- Issues in-order instruction-memory requests with a req/gnt handshake and buffers returned words with their PCs in an in-order queue.
- Presents instructions to decode over a valid/ready handshake and flushes cleanly on branch/jump redirect.

---
 rtl/instr_fetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage wrapped around an external PC register. Computes the next PC,
//   issues in-order instruction-memory requests (req/gnt), buffers returned
//   words with their PCs in an in-order queue and hands them to decode over a
//   valid/ready handshake. A redirect flushes the queue; responses still in
//   flight for flushed requests are counted in kill_cnt and discarded on return.
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   : a redirect to a target with [1:0] != 0 enqueues a single fault
//               entry (instr = 32'h00000013) and fetching stops until the next
//               redirect.
//   undefined : the low two bits of the redirect target are forced to zero and
//               o_if_fault is always 0.
//
// Ports
//   clk, a_reset_n              clock, synchronous active-low reset
//   i_pc / o_next_pc            PC register output / PC register input
//   i_redirect, i_redirect_pc   one-cycle redirect pulse and its target
//   o_imem_req, o_imem_addr,
//   i_imem_gnt                  request channel (address = i_pc)
//   i_imem_rvalid, i_imem_rdata in-order response channel
//   o_if_valid, o_if_instr,
//   o_if_pc, o_if_fault,
//   i_id_ready                  decode handshake on the queue head
// -----------------------------------------------------------------------------

module instr_fetch_unit_chk (
   input logic clk,
   input logic a_reset_n,
   input logic rvalid,
   input logic has_unfilled,
   input logic has_kill
);
   // Every response must belong to either a queued request or a killed one.
   orphan_rvalid: assert property (@(posedge clk) disable iff (!a_reset_n)
                                   rvalid |-> (has_unfilled || has_kill));
endmodule

module instr_fetch_unit #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = {WIDTH{1'b0}},
   parameter int               FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             a_reset_n,
   input  logic [WIDTH-1:0] i_pc,
   output logic [WIDTH-1:0] o_next_pc,
   input  logic             i_redirect,
   input  logic [WIDTH-1:0] i_redirect_pc,
   output logic             o_imem_req,
   output logic [WIDTH-1:0] o_imem_addr,
   input  logic             i_imem_gnt,
   input  logic             i_imem_rvalid,
   input  logic [31:0]      i_imem_rdata,
   output logic             o_if_valid,
   output logic [31:0]      o_if_instr,
   output logic [WIDTH-1:0] o_if_pc,
   output logic             o_if_fault,
   input  logic             i_id_ready
);

`ifdef IFU_MISALIGN_CHECK_EN
   localparam bit MISALIGN_CHECK = 1'b1;
`else
   localparam bit MISALIGN_CHECK = 1'b0;
`endif

   localparam int              PTR_W = $clog2(FIFO_DEPTH);
   // Pointers carry one wrap bit so that full and empty are distinguishable.
   localparam int              CNT_W = PTR_W + 1;
   localparam logic [31:0]     NOP   = 32'h0000_0013;
   localparam logic [PTR_W-1:0] IDX0 = {PTR_W{1'b0}};

   logic [WIDTH-1:0]      pc_mem    [FIFO_DEPTH];
   logic [31:0]           instr_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] filled_vec;
   logic [FIFO_DEPTH-1:0] fault_vec;
   logic [CNT_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      fill_ptr;
   logic [CNT_W-1:0]      kill_cnt;
   logic                  halt;

   logic [CNT_W-1:0]      occupancy;
   logic [CNT_W-1:0]      unfilled;
   logic [CNT_W:0]        budget;
   logic [CNT_W-1:0]      kill_next;
   logic                  misaligned;
   logic                  grant;
   logic                  rv_kill;
   logic                  rv_fill;
   logic                  deq;

   wire [PTR_W-1:0] rd_idx   = rd_ptr[PTR_W-1:0];
   wire [PTR_W-1:0] wr_idx   = wr_ptr[PTR_W-1:0];
   wire [PTR_W-1:0] fill_idx = fill_ptr[PTR_W-1:0];

   assign o_imem_addr = i_pc;
   assign o_if_instr  = instr_mem[rd_idx];
   assign o_if_pc     = pc_mem[rd_idx];

   // Queue status, issue decision, response routing and kill bookkeeping.
   always_comb begin
      occupancy  = wr_ptr - rd_ptr;
      unfilled   = wr_ptr - fill_ptr;
      // Killed responses still hold a slot so the queue can never be overrun.
      budget     = {1'b0, occupancy} + {1'b0, kill_cnt};
      misaligned = MISALIGN_CHECK && (i_redirect_pc[1:0] != 2'b00);
      o_imem_req = a_reset_n && !i_redirect && !halt &&
                   (budget < (CNT_W+1)'(FIFO_DEPTH));
      grant      = o_imem_req && i_imem_gnt;
      // Stale responses are always older than anything still queued.
      rv_kill    = i_imem_rvalid && (kill_cnt != {CNT_W{1'b0}});
      rv_fill    = i_imem_rvalid && (kill_cnt == {CNT_W{1'b0}}) &&
                   (unfilled != {CNT_W{1'b0}});
      o_if_valid = (occupancy != {CNT_W{1'b0}}) && filled_vec[rd_idx];
      o_if_fault = MISALIGN_CHECK ? (o_if_valid && fault_vec[rd_idx]) : 1'b0;
      deq        = o_if_valid && i_id_ready;
      // A response arriving in the redirect cycle retires its own entry.
      kill_next  = kill_cnt - CNT_W'(rv_kill) +
                   (i_redirect ? (unfilled - CNT_W'(rv_fill)) : {CNT_W{1'b0}});
   end

   // Next-PC selection: redirect, then sequential advance on grant, else hold.
   always_comb begin
      if (!a_reset_n) begin
         o_next_pc = RESET_PC;
      end else if (i_redirect) begin
         o_next_pc = MISALIGN_CHECK ? i_redirect_pc
                                    : {i_redirect_pc[WIDTH-1:2], 2'b00};
      end else if (grant) begin
         o_next_pc = i_pc + WIDTH'(32'd4);
      end else begin
         o_next_pc = i_pc;
      end
   end

   // Queue storage, pointers, kill counter and misalign halt flag.
   always_ff @(posedge clk) begin
      if (!a_reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pc_mem[i]    <= {WIDTH{1'b0}};
            instr_mem[i] <= 32'h0000_0000;
         end
         filled_vec <= {FIFO_DEPTH{1'b0}};
         fault_vec  <= {FIFO_DEPTH{1'b0}};
         rd_ptr     <= {CNT_W{1'b0}};
         wr_ptr     <= {CNT_W{1'b0}};
         fill_ptr   <= {CNT_W{1'b0}};
         kill_cnt   <= {CNT_W{1'b0}};
         halt       <= 1'b0;
      end else if (i_redirect) begin
         rd_ptr   <= {CNT_W{1'b0}};
         kill_cnt <= kill_next;
         halt     <= misaligned;
         if (misaligned) begin
            pc_mem[IDX0]     <= i_redirect_pc;
            instr_mem[IDX0]  <= NOP;
            filled_vec[IDX0] <= 1'b1;
            fault_vec[IDX0]  <= 1'b1;
            wr_ptr           <= CNT_W'(1'b1);
            fill_ptr         <= CNT_W'(1'b1);
         end else begin
            wr_ptr   <= {CNT_W{1'b0}};
            fill_ptr <= {CNT_W{1'b0}};
         end
      end else begin
         kill_cnt <= kill_next;
         if (grant) begin
            pc_mem[wr_idx]     <= i_pc;
            filled_vec[wr_idx] <= 1'b0;
            fault_vec[wr_idx]  <= 1'b0;
            wr_ptr             <= wr_ptr + CNT_W'(1'b1);
         end
         if (rv_fill) begin
            instr_mem[fill_idx]  <= i_imem_rdata;
            filled_vec[fill_idx] <= 1'b1;
            fill_ptr             <= fill_ptr + CNT_W'(1'b1);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + CNT_W'(1'b1);
         end
      end
   end

   instr_fetch_unit_chk u_chk (
      .clk          (clk),
      .a_reset_n    (a_reset_n),
      .rvalid       (i_imem_rvalid),
      .has_unfilled (unfilled != {CNT_W{1'b0}}),
      .has_kill     (kill_cnt != {CNT_W{1'b0}})
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. The bench plays the PC register and an
//   in-order instruction memory of programmable latency; memory word at address
//   A is 32'hC000_0000 ^ A. Expected values are hand-derived cycle by cycle,
//   with cycle 1 being the first cycle after reset is released.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_fault;
   logic        id_ready;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_grant  = 0;
   int          cyc      = 0;
   int          lat      = 1;
   logic [31:0] mem_addr [$];
   int          mem_due  [$];
   logic [31:0] log_pc   [$];
   logic [31:0] log_instr[$];

   instr_fetch_unit dut (
      .clk           (clk),
      .a_reset_n     (reset_n),
      .i_pc          (pc),
      .o_next_pc     (next_pc),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_gnt    (imem_gnt),
      .i_imem_rvalid (imem_rvalid),
      .i_imem_rdata  (imem_rdata),
      .o_if_valid    (if_valid),
      .o_if_instr    (if_instr),
      .o_if_pc       (if_pc),
      .o_if_fault    (if_fault),
      .i_id_ready    (id_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Close the current cycle: record grants and handshakes, clock the PC
   // register, then present this cycle's memory response.
   task automatic cycle();
      logic [31:0] nxt;
      nxt = next_pc;
      if (imem_req && imem_gnt) begin
         mem_addr.push_back(imem_addr);
         mem_due.push_back(cyc + lat);
         n_grant++;
      end
      if (if_valid && id_ready) begin
         log_pc.push_back(if_pc);
         log_instr.push_back(if_instr);
      end
      @(posedge clk);
      #1;
      cyc++;
      pc       = nxt;
      redirect = 1'b0;
      if (mem_addr.size() != 0 && mem_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hC000_0000 ^ mem_addr[0];
         void'(mem_addr.pop_front());
         void'(mem_due.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0000_0000;
      end
      #1;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      redirect = 1'b0;
      cycle();
      cycle();
      mem_addr.delete();
      mem_due.delete();
      log_pc.delete();
      log_instr.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0000_0000;
      n_grant     = 0;
      #1;
   endtask

   task automatic release_reset();
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      pc          = 32'h0000_0000;
      redirect    = 1'b0;
      redirect_pc = 32'h0000_0000;
      imem_gnt    = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0000_0000;
      id_ready    = 1'b1;
      lat         = 1;

      // ---- reset state, then streaming with L=1 ----
      do_reset();
      chk("rst_req",    {31'd0, imem_req}, 32'd0);
      chk("rst_nextpc", next_pc, 32'h0000_0000);
      chk("rst_valid",  {31'd0, if_valid}, 32'd0);
      chk("rst_fault",  {31'd0, if_fault}, 32'd0);
      release_reset();
      chk("c1_addr",   imem_addr, 32'h0000_0000);
      chk("c1_req",    {31'd0, imem_req}, 32'd1);
      chk("c1_nextpc", next_pc, 32'h0000_0004);
      chk("c1_valid",  {31'd0, if_valid}, 32'd0);
      cycle();
      chk("c2_addr",   imem_addr, 32'h0000_0004);
      chk("c2_valid",  {31'd0, if_valid}, 32'd0);
      cycle();
      chk("c3_addr",   imem_addr, 32'h0000_0008);
      chk("c3_valid",  {31'd0, if_valid}, 32'd1);
      chk("c3_pc",     if_pc, 32'h0000_0000);
      chk("c3_instr",  if_instr, 32'hC000_0000);
      cycle();
      chk("c4_pc",     if_pc, 32'h0000_0004);
      chk("c4_instr",  if_instr, 32'hC000_0004);
      cycle();
      chk("c5_pc",     if_pc, 32'h0000_0008);
      chk("c5_valid",  {31'd0, if_valid}, 32'd1);

      // ---- decode stalled for 10 cycles ----
      do_reset();
      id_ready = 1'b0;
      release_reset();
      for (int i = 0; i < 10; i++) cycle();
      chk("stall_grants", n_grant, 32'd4);
      chk("stall_req",    {31'd0, imem_req}, 32'd0);
      chk("stall_nextpc", next_pc, 32'h0000_0010);
      chk("stall_valid",  {31'd0, if_valid}, 32'd1);
      chk("stall_pc",     if_pc, 32'h0000_0000);
      chk("stall_instr",  if_instr, 32'hC000_0000);
      id_ready = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) cycle();
      chk("drain_count_ge4", {31'd0, log_pc.size() >= 4}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i < log_pc.size()) begin
            chk($sformatf("drain_pc%0d", i),    log_pc[i],    32'(i * 4));
            chk($sformatf("drain_instr%0d", i), log_instr[i], 32'hC000_0000 | 32'(i * 4));
         end
      end

      // ---- L=3, redirect with two requests outstanding ----
      do_reset();
      lat = 3;
      release_reset();
      chk("k_c1_addr", imem_addr, 32'h0000_0000);
      cycle();
      chk("k_c2_addr", imem_addr, 32'h0000_0004);
      cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      #1;
      chk("k_redir_req",    {31'd0, imem_req}, 32'd0);
      chk("k_redir_nextpc", next_pc, 32'h0000_0100);
      cycle();
      chk("k_c4_addr",  imem_addr, 32'h0000_0100);
      chk("k_c4_req",   {31'd0, imem_req}, 32'd1);
      chk("k_c4_valid", {31'd0, if_valid}, 32'd0);
      cycle();
      chk("k_c5_valid", {31'd0, if_valid}, 32'd0);
      cycle();
      chk("k_c6_valid", {31'd0, if_valid}, 32'd0);
      cycle();
      chk("k_c7_valid", {31'd0, if_valid}, 32'd0);
      cycle();
      chk("k_c8_valid", {31'd0, if_valid}, 32'd1);
      chk("k_c8_pc",    if_pc, 32'h0000_0100);
      chk("k_c8_instr", if_instr, 32'hC000_0100);

      // ---- redirect together with rvalid and a decode handshake ----
      do_reset();
      lat = 1;
      release_reset();
      cycle();
      cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      #1;
      chk("r_c3_valid",  {31'd0, if_valid}, 32'd1);
      chk("r_c3_pc",     if_pc, 32'h0000_0000);
      chk("r_c3_rvalid", {31'd0, imem_rvalid}, 32'd1);
      chk("r_c3_req",    {31'd0, imem_req}, 32'd0);
      chk("r_c3_nextpc", next_pc, 32'h0000_0200);
      cycle();
      chk("r_c4_valid",  {31'd0, if_valid}, 32'd0);
      chk("r_c4_hs",     log_pc.size(), 32'd1);
      chk("r_c4_addr",   imem_addr, 32'h0000_0200);
      cycle();
      chk("r_c5_valid",  {31'd0, if_valid}, 32'd0);
      cycle();
      chk("r_c6_valid",  {31'd0, if_valid}, 32'd1);
      chk("r_c6_pc",     if_pc, 32'h0000_0200);
      chk("r_c6_instr",  if_instr, 32'hC000_0200);

      // ---- PC wrap and hold without grant ----
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      #1;
      cycle();
      chk("w_addr",   imem_addr, 32'hFFFF_FFFC);
      chk("w_req",    {31'd0, imem_req}, 32'd1);
      chk("w_nextpc", next_pc, 32'h0000_0000);
      imem_gnt = 1'b0;
      #1;
      chk("w_hold_nextpc", next_pc, 32'hFFFF_FFFC);
      cycle();
      chk("w_hold_addr",   imem_addr, 32'hFFFF_FFFC);
      chk("w_hold_req",    {31'd0, imem_req}, 32'd1);
      imem_gnt = 1'b1;
      #1;
      chk("w_grant_nextpc", next_pc, 32'h0000_0000);
      cycle();
      chk("w_after_addr",   imem_addr, 32'h0000_0000);

      // ---- misaligned redirect target ----
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      #1;
`ifdef IFU_MISALIGN_CHECK_EN
      chk("m_nextpc", next_pc, 32'h0000_0102);
      cycle();
      chk("m_valid",  {31'd0, if_valid}, 32'd1);
      chk("m_fault",  {31'd0, if_fault}, 32'd1);
      chk("m_pc",     if_pc, 32'h0000_0102);
      chk("m_instr",  if_instr, 32'h0000_0013);
      chk("m_req",    {31'd0, imem_req}, 32'd0);
      cycle();
      chk("m_after_valid",  {31'd0, if_valid}, 32'd0);
      chk("m_after_req",    {31'd0, imem_req}, 32'd0);
      chk("m_after_nextpc", next_pc, 32'h0000_0102);
`else
      chk("m_nextpc", next_pc, 32'h0000_0100);
      cycle();
      chk("m_addr",   imem_addr, 32'h0000_0100);
      chk("m_req",    {31'd0, imem_req}, 32'd1);
      chk("m_valid",  {31'd0, if_valid}, 32'd0);
      chk("m_fault",  {31'd0, if_fault}, 32'd0);
      cycle();
      cycle();
      chk("m_dlv_valid", {31'd0, if_valid}, 32'd1);
      chk("m_dlv_pc",    if_pc, 32'h0000_0100);
      chk("m_dlv_fault", {31'd0, if_fault}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
